fetch_unit: RTL
===============

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 8'h00, PC value loaded on reset.
REQ-002 SHALL have parameter HALT_OPCODE, default 4'b0110, opcode (instr[15:12]) that stops fetching.
REQ-003 SHALL have port clk  input  1  single clock, all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port imem_addr  output  8  address to instruction memory.
REQ-006 SHALL have port imem_data  input  16  instruction returned combinationally for imem_addr, same cycle.
REQ-007 SHALL have port ir  output  16  registered instruction offered to decode.
REQ-008 SHALL have port ir_pc  output  8  address from which ir was fetched.
REQ-009 SHALL have port ir_valid  output  1  ir/ir_pc hold a valid instruction.
REQ-010 SHALL have port ir_ready  input  1  decode accepts ir this cycle.
REQ-011 SHALL have port redirect  input  1  jump request, 1-cycle pulse.
REQ-012 SHALL have port redirect_pc  input  8  jump target, sampled when redirect=1.
REQ-013 SHALL have port resume  input  1  leave HALTED state.
REQ-014 SHALL have port halted  output  1  state is HALTED.
REQ-015 SHALL have port fetch_count  output  16  number of instructions captured into ir.

Function
REQ-016 SHALL drive imem_addr directly from the internal 8-bit pc register (no added latency).
REQ-017 SHALL have two states, RUN and HALTED; halted=1 iff state=HALTED.
REQ-018 SHALL define transfer as ir_valid=1 and ir_ready=1 at a rising edge; ir SHALL be held stable while ir_valid=1 and ir_ready=0.
REQ-019 SHALL define capture as: state=RUN, redirect=0, and (ir_valid=0 or transfer); on capture ir<=imem_data, ir_pc<=pc, ir_valid<=1, pc<=pc+1, fetch_count<=fetch_count+1.
REQ-020 SHALL give fetch latency of one cycle: instruction at pc appears on ir the edge after capture; back-to-back captures sustain one instruction per cycle while ir_ready=1.
REQ-021 SHALL, on transfer without capture, clear ir_valid to 0.
REQ-022 SHALL wrap pc modulo 256 (8'hFF+1 = 8'h00); fetch_count SHALL wrap modulo 65536.
REQ-023 SHALL, when a captured instruction has instr[15:12]=HALT_OPCODE, enter HALTED on the same edge; the HALT instruction itself is still delivered on ir; pc then holds HALT address+1.
REQ-024 SHALL perform no capture in HALTED; ir/ir_valid continue to drain via REQ-018/REQ-021.
REQ-025 SHALL, on resume=1 in HALTED with redirect=0, return to RUN on the next edge; first capture occurs the edge after that; resume SHALL be ignored in RUN.
REQ-026 SHALL, on redirect=1 (any state), at the edge: pc<=redirect_pc, ir_valid<=0 (flush), state<=RUN; no capture that cycle; fetch_count unchanged.
REQ-027 SHALL give redirect priority over capture, HALT detection and resume when simultaneous; a concurrent transfer still counts as completed by decode.
REQ-028 SHALL not alter ir or ir_pc on flush; only ir_valid clears.

Reset
REQ-029 SHALL, when rst=1 at an edge, set pc=RESET_PC, ir=16'h0000, ir_pc=8'h00, ir_valid=0, state=RUN, halted=0, fetch_count=0, overriding redirect, resume and any in-flight handshake.
REQ-030 SHALL perform first capture on the first edge with rst=0.

Verification
REQ-031 SHALL verify streaming: memory[0..3]=ADDI words, ir_ready=1 after reset -> ir_valid rises 1 cycle after rst release, ir_pc = 0,1,2,3 on consecutive cycles, fetch_count=4.
REQ-032 SHALL verify stall: ir_ready=0 for 3 cycles holding ir_pc=2 -> ir, ir_pc, pc, fetch_count constant; ir_ready=1 -> ir_pc=3 next cycle.
REQ-033 SHALL verify halt: 16'h6006 at address 13 -> delivered with ir_pc=13, halted=1 same edge, imem_addr=14 held, no further captures; resume pulse -> ir_pc=14 two edges later.
REQ-034 SHALL verify redirect: redirect=1, redirect_pc=8'h06 while ir_valid=1 -> next edge ir_valid=0, imem_addr=6; following edge ir_pc=6; redirect during HALTED clears halted.
REQ-035 SHALL verify wrap: RESET_PC=8'hFE -> ir_pc sequence FE, FF, 00.
REQ-036 SHALL verify reset mid-stream: rst=1 with ir_valid=1 and halted=1 -> all outputs at REQ-029 values after the edge.

Source files
------------

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - single-entry instruction fetch stage with halt, resume and redirect
module fetch_unit #(
    parameter logic [7:0] RESET_PC    = 8'h00,
    parameter logic [3:0] HALT_OPCODE = 4'b0110
) (
    input  logic        clk,
    input  logic        rst,
    output logic [7:0]  imem_addr,
    input  logic [15:0] imem_data,
    output logic [15:0] ir,
    output logic [7:0]  ir_pc,
    output logic        ir_valid,
    input  logic        ir_ready,
    input  logic        redirect,
    input  logic [7:0]  redirect_pc,
    input  logic        resume,
    output logic        halted,
    output logic [15:0] fetch_count
);

    typedef enum logic {
        ST_RUN    = 1'b0,
        ST_HALTED = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  pc_q, pc_d;
    logic [15:0] ir_q, ir_d;
    logic [7:0]  ir_pc_q, ir_pc_d;
    logic        ir_valid_q, ir_valid_d;
    logic [15:0] fetch_count_q, fetch_count_d;

    logic transfer;
    logic capture;

    assign transfer = ir_valid_q & ir_ready;
    // The ir slot may be refilled when it is empty or being drained this same edge.
    assign capture  = (state_q == ST_RUN) & ~redirect & (~ir_valid_q | transfer);

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        ir_d          = ir_q;
        ir_pc_d       = ir_pc_q;
        ir_valid_d    = ir_valid_q;
        fetch_count_d = fetch_count_q;

        if (redirect) begin
            // Flush only drops valid; ir and ir_pc keep their last contents.
            pc_d       = redirect_pc;
            ir_valid_d = 1'b0;
            state_d    = ST_RUN;
        end else begin
            if (capture) begin
                ir_d          = imem_data;
                ir_pc_d       = pc_q;
                ir_valid_d    = 1'b1;
                pc_d          = pc_q + 8'd1;
                fetch_count_d = fetch_count_q + 16'd1;
                if (imem_data[15:12] == HALT_OPCODE) begin
                    state_d = ST_HALTED;
                end
            end else if (transfer) begin
                ir_valid_d = 1'b0;
            end

            if ((state_q == ST_HALTED) && resume) begin
                state_d = ST_RUN;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_RUN;
            pc_q          <= RESET_PC;
            ir_q          <= 16'h0000;
            ir_pc_q       <= 8'h00;
            ir_valid_q    <= 1'b0;
            fetch_count_q <= 16'h0000;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            ir_q          <= ir_d;
            ir_pc_q       <= ir_pc_d;
            ir_valid_q    <= ir_valid_d;
            fetch_count_q <= fetch_count_d;
        end
    end

    assign imem_addr   = pc_q;
    assign ir          = ir_q;
    assign ir_pc       = ir_pc_q;
    assign ir_valid    = ir_valid_q;
    assign halted      = (state_q == ST_HALTED);
    assign fetch_count = fetch_count_q;

endmodule
